// File: rtl/ad7606_pkg.sv
// Shared types and limits for the AD7606 parallel-bus controller.
// Imported by the timer, the bus interface and the controller top.
package ad7606_pkg;

  typedef enum logic [2:0] {
    PRST,
    IDLE,
    CVT,
    WAIT_H,
    WAIT_L,
    RD_LO,
    RD_HI
  } state_t;

  typedef enum logic [2:0] {
    OS_NONE = 3'd0,
    OS_X2   = 3'd1,
    OS_X4   = 3'd2,
    OS_X8   = 3'd3,
    OS_X16  = 3'd4,
    OS_X32  = 3'd5,
    OS_X64  = 3'd6,
    OS_BAD  = 3'd7
  } os_t;

  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 8;
  localparam int DATA_W_MIN = 12;
  localparam int DATA_W_MAX = 16;
  localparam int CNT_W      = 16;

  // Two's complement widen of a DATA_W-bit word into 16 bits.
  function automatic logic [15:0] sext(
    input logic [15:0] d,
    input int          w
  );
    logic [15:0] r;
    for (int i = 0; i < 16; i++)
      r[i] = (i < w) ? d[i] : d[w-1];
    return r;
  endfunction

endpackage

// File: rtl/ad7606_stream_ctrl_if.sv
// ADC pin bundle plus the per-channel result stream.
// master = controller side, slave = ADC / sink side.
interface ad7606_stream_ctrl_if;
  import ad7606_pkg::*;

  logic        busy;
  logic [15:0] db;
  logic        phy_rst;
  logic        cvt;
  logic        cs;
  logic        rd;
  logic [2:0]  os;
  logic [15:0] ch_data;
  logic [2:0]  ch_idx;
  logic        ch_valid;
  logic        frame_done;

  modport master (
    input  busy, db,
    output phy_rst, cvt, cs, rd, os,
    output ch_data, ch_idx, ch_valid, frame_done
  );

  modport slave (
    output busy, db,
    input  phy_rst, cvt, cs, rd, os,
    input  ch_data, ch_idx, ch_valid, frame_done
  );
endinterface

// File: rtl/ad7606_rate_timer.sv
// Free-running sample-period down-counter, reloads from div_val on zero.
// Held at zero while disabled so the first tick follows enable at once.
module ad7606_rate_timer
  import ad7606_pkg::*;
#(
  parameter int DIV_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = ena & (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (!ena)
      cnt <= '0;
    else if (cnt == '0)
      cnt <= div_val;
    else
      cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/ad7606_stream_ctrl.sv
// AD7606 conversion/readout sequencer with per-channel result stream.
// All pins and strobes come straight from flops.
module ad7606_stream_ctrl
  import ad7606_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 16,
  parameter int RST_CYC = 8,
  parameter int CVT_LOW = 2,
  parameter int RD_LOW  = 2,
  parameter int RD_HIGH = 1,
  parameter int TMO_CYC = 4096,
  parameter int DIV_W   = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             auto_mode,
  input  logic [DIV_W-1:0] div_val,
  input  logic             trig,
  input  logic [2:0]       os_sel,
  ad7606_stream_ctrl_if.master bus,
  output logic             overrun,
  output logic             tmo_err
);

  localparam logic [2:0] LAST = 3'(NUM_CH - 1);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX ||
      DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad
    $error("ad7606_stream_ctrl: NUM_CH/DATA_W out of range");
  end

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       ch, ch_nx;
  logic             phy_q, cvt_q, cs_q, rd_q;
  logic             phy_nx, cvt_nx, cs_nx, rd_nx;
  os_t              os_q, os_nx;
  logic             tick, req;
  logic             cap_nx, tmo_nx, ovr_nx;
  logic             cap_v, cap_last;
  logic [15:0]      cap_d;
  logic [2:0]       cap_i;
  logic [15:0]      data_q;
  logic [2:0]       idx_q;
  logic             valid_q, done_q;

  ad7606_rate_timer #(.DIV_W(DIV_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .ena     (auto_mode & en),
    .div_val (div_val),
    .tick    (tick)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    ch_nx    = ch;
    phy_nx   = phy_q;
    cvt_nx   = cvt_q;
    cs_nx    = cs_q;
    rd_nx    = rd_q;
    os_nx    = os_q;
    cap_nx   = 1'b0;
    tmo_nx   = 1'b0;
    req      = auto_mode ? tick : trig;
    ovr_nx   = req & ((state != IDLE) | bus.busy);
    unique case (state)
      PRST:
        if (cnt == CNT_W'(RST_CYC - 1)) begin
          phy_nx   = 1'b0;
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      IDLE: begin
        os_nx  = os_t'(os_sel);
        cnt_nx = '0;
        if (en & req & !bus.busy) begin
          state_nx = CVT;
          cvt_nx   = 1'b0;
        end
      end
      CVT:
        if (cnt == CNT_W'(CVT_LOW - 1)) begin
          cvt_nx   = 1'b1;
          state_nx = WAIT_H;
          cnt_nx   = '0;
        end
      WAIT_H:
        if (bus.busy) begin
          state_nx = WAIT_L;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(TMO_CYC - 1)) begin
          tmo_nx = 1'b1;
        end
      WAIT_L:
        if (!bus.busy) begin
          state_nx = RD_LO;
          cs_nx    = 1'b0;
          rd_nx    = 1'b0;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(TMO_CYC - 1)) begin
          tmo_nx = 1'b1;
        end
      RD_LO:
        if (cnt == CNT_W'(RD_LOW - 1)) begin
          cap_nx   = 1'b1;
          rd_nx    = 1'b1;
          state_nx = RD_HI;
          cnt_nx   = '0;
          // cs rises with rd after the last word
          if (ch == LAST) begin
            cs_nx = 1'b1;
            ch_nx = '0;
          end else begin
            ch_nx = ch + 3'd1;
          end
        end
      RD_HI:
        if (cnt == CNT_W'(RD_HIGH - 1)) begin
          cnt_nx   = '0;
          state_nx = cs_q ? IDLE : RD_LO;
          rd_nx    = cs_q;
        end
      default: state_nx = PRST;
    endcase
    if (tmo_nx) begin
      state_nx = IDLE;
      cs_nx    = 1'b1;
      rd_nx    = 1'b1;
      cvt_nx   = 1'b1;
      ch_nx    = '0;
      cnt_nx   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PRST;
      cnt      <= '0;
      ch       <= '0;
      phy_q    <= 1'b1;
      cvt_q    <= 1'b1;
      cs_q     <= 1'b1;
      rd_q     <= 1'b1;
      os_q     <= OS_NONE;
      overrun  <= 1'b0;
      tmo_err  <= 1'b0;
      cap_v    <= 1'b0;
      cap_last <= 1'b0;
      cap_d    <= '0;
      cap_i    <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      ch      <= ch_nx;
      phy_q   <= phy_nx;
      cvt_q   <= cvt_nx;
      cs_q    <= cs_nx;
      rd_q    <= rd_nx;
      os_q    <= os_nx;
      overrun <= ovr_nx;
      tmo_err <= tmo_nx;
      cap_v   <= cap_nx;
      if (cap_nx) begin
        cap_d    <= bus.db;
        cap_i    <= ch;
        cap_last <= (ch == LAST);
      end
      valid_q <= cap_v;
      done_q  <= cap_v & cap_last;
      if (cap_v) begin
        data_q <= sext(cap_d, DATA_W);
        idx_q  <= cap_i;
      end
    end
  end

  assign bus.phy_rst    = phy_q;
  assign bus.cvt        = cvt_q;
  assign bus.cs         = cs_q;
  assign bus.rd         = rd_q;
  assign bus.os         = os_q;
  assign bus.ch_data    = data_q;
  assign bus.ch_idx     = idx_q;
  assign bus.ch_valid   = valid_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_ad7606_stream_ctrl.sv
// Directed bench: reset, manual/auto frames, narrow variant, timeout,
// overrun and mid-read reset, with a small behavioural ADC model.
module tb_ad7606_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        auto_mode = 1'b0;
  logic        trig = 1'b0;
  logic        trig2 = 1'b0;
  logic        busy_en = 1'b0;
  logic [19:0] div_val = '0;
  logic [2:0]  os_sel = 3'd5;
  logic        ovr, tmo, ovr2, tmo2;
  int          errors = 0;
  int          checks = 0;

  ad7606_stream_ctrl_if a_if ();
  ad7606_stream_ctrl_if b_if ();

  always #5 clk = ~clk;

  ad7606_stream_ctrl #(.TMO_CYC(64)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .auto_mode (auto_mode),
    .div_val   (div_val),
    .trig      (trig),
    .os_sel    (os_sel),
    .bus       (a_if),
    .overrun   (ovr),
    .tmo_err   (tmo)
  );

  ad7606_stream_ctrl #(
    .NUM_CH (4),
    .DATA_W (14),
    .TMO_CYC(64)
  ) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .auto_mode (1'b0),
    .div_val   (div_val),
    .trig      (trig2),
    .os_sel    (os_sel),
    .bus       (b_if),
    .overrun   (ovr2),
    .tmo_err   (tmo2)
  );

  assign b_if.db = 16'h2001;

  // BUSY: rises after CONVST returns high, held 40 cycles.
  initial begin
    a_if.busy = 1'b0;
    forever begin
      @(negedge a_if.cvt);
      if (busy_en) begin
        @(posedge a_if.cvt);
        #1 a_if.busy = 1'b1;
        repeat (40) @(posedge clk);
        #1 a_if.busy = 1'b0;
      end
    end
  end

  // Data bus: word n of a burst reads 0x1000+n.
  initial begin
    int   n;
    logic rp;
    n = 0;
    rp = 1'b1;
    a_if.db = '0;
    forever begin
      @(negedge clk);
      if (a_if.cs) n = 0;
      else if (rp && !a_if.rd) begin
        a_if.db = 16'h1000 + 16'(n);
        n++;
      end
      rp = a_if.rd;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int ovr_k);
    int   k, t, bfall, first;
    logic hi, pend;
    k = 0; t = 0; bfall = -1; first = -1;
    hi = 1'b0; pend = 1'b0;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("cvt_lat", a_if.cvt, 0);
    while (k < 8 && t < 400) begin
      @(negedge clk);
      t++;
      if (a_if.busy) hi = 1'b1;
      else if (hi && bfall < 0) bfall = t;
      if (pend) begin
        chk("overrun", ovr, 1);
        pend = 1'b0;
        trig = 1'b0;
      end
      if (a_if.ch_valid) begin
        if (first < 0) first = t;
        chk("ch_idx", a_if.ch_idx, k[2:0]);
        chk("ch_data", a_if.ch_data, 32'h1000 + k);
        chk("frame_done", a_if.frame_done, k == 7);
        if (k == ovr_k) begin
          trig = 1'b1;
          pend = 1'b1;
        end
        k++;
      end
    end
    chk("n_valid", k, 8);
    chk("busy_lat", first - bfall, 4);
    chk("cs_end", a_if.cs, 1);
    chk("rd_end", a_if.rd, 1);
  endtask

  initial begin
    int   n, t, nf, last, extra, nrd, nv, nfd;
    logic strobe, prev, low;

    // reset state and PRST length
    @(negedge clk);
    chk("rst_phy", a_if.phy_rst, 1);
    chk("rst_cvt", a_if.cvt, 1);
    chk("rst_cs", a_if.cs, 1);
    chk("rst_rd", a_if.rd, 1);
    chk("rst_os", a_if.os, 0);
    chk("rst_data", a_if.ch_data, 0);
    chk("rst_valid", a_if.ch_valid, 0);
    rst = 1'b0;
    n = 0;
    strobe = 1'b0;
    while (a_if.phy_rst && n < 50) begin
      n++;
      strobe |= ovr | tmo | a_if.ch_valid | a_if.frame_done;
      @(negedge clk);
    end
    chk("phy_rst_len", n, 8);
    chk("prst_strobes", strobe, 0);
    step(1);
    chk("os_idle", a_if.os, 5);

    // manual frame
    en = 1'b1;
    busy_en = 1'b1;
    frame(-1);
    step(3);

    // trigger during read phase is dropped
    frame(3);
    low = 1'b0;
    repeat (10) begin
      @(negedge clk);
      low |= ~a_if.cvt;
    end
    chk("no_queue", low, 0);

    // busy never rises: timeout
    busy_en = 1'b0;
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    n = 0;
    while (!a_if.cvt && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!tmo && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_at", n, 64);
    chk("tmo_cs", a_if.cs, 1);
    chk("tmo_cvt", a_if.cvt, 1);
    chk("tmo_fd", a_if.frame_done, 0);
    step(1);
    chk("tmo_pulse", tmo, 0);
    busy_en = 1'b1;
    step(2);
    frame(-1);

    // auto mode period
    step(3);
    div_val = 20'd199;
    auto_mode = 1'b1;
    prev = 1'b1; t = 0; nf = 0; last = 0;
    while (nf < 5 && t < 1500) begin
      @(negedge clk);
      t++;
      if (prev && !a_if.cvt) begin
        if (nf > 0) chk("period", t - last, 200);
        last = t;
        nf++;
      end
      prev = a_if.cvt;
    end
    chk("n_frames", nf, 5);
    en = 1'b0;
    extra = 0;
    repeat (250) begin
      @(negedge clk);
      if (prev && !a_if.cvt) extra++;
      prev = a_if.cvt;
    end
    chk("en_off", extra, 0);
    chk("en_off_cs", a_if.cs, 1);
    auto_mode = 1'b0;
    en = 1'b1;

    // 14-bit, 4-channel variant
    trig2 = 1'b1;
    @(negedge clk);
    trig2 = 1'b0;
    chk("cvt2_lat", b_if.cvt, 0);
    step(3);
    b_if.busy = 1'b1;
    step(10);
    b_if.busy = 1'b0;
    nrd = 0; nv = 0; nfd = 0; prev = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (prev && !b_if.rd) nrd++;
      prev = b_if.rd;
      if (b_if.ch_valid) begin
        chk("ch_data14", b_if.ch_data, 16'hE001);
        chk("idx2", b_if.ch_idx, nv[2:0]);
        nfd += int'(b_if.frame_done);
        nv++;
      end
    end
    chk("rd2_pulses", nrd, 4);
    chk("valid2", nv, 4);
    chk("fd2", nfd, 1);
    chk("cs2_end", b_if.cs, 1);

    // reset in the middle of a read burst
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    n = 0;
    while (a_if.rd && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rd_low_seen", a_if.rd, 0);
    chk("cs_low_seen", a_if.cs, 0);
    rst = 1'b1;
    #1;
    chk("arst_rd", a_if.rd, 1);
    chk("arst_cs", a_if.cs, 1);
    chk("arst_phy", a_if.phy_rst, 1);
    @(negedge clk);
    rst = 1'b0;
    step(12);
    chk("rerun_phy", a_if.phy_rst, 0);
    frame(-1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
